lc3_mem_ctrl: RTL and testbench

//  Memory-access stage downstream of the LC-3 address adder. Holds MAR/MDR and runs the

---
 rtl/lc3_mem_ctrl_pkg.sv | 22 ++
 rtl/lc3_io_regs.sv | 78 +++++++
 rtl/lc3_mem_ctrl.sv | 139 +++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_ctrl_pkg.sv
// rtl/lc3_mem_ctrl_pkg.sv - shared I/O addresses, FSM states and decode helper for the LC-3 memory stage
package lc3_mem_ctrl_pkg;

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam int          WAIT_MAX_DEFAULT = 255;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Only the four exact device addresses are internal; the rest of xFExx goes out.
    function automatic logic is_io_addr(input logic [15:0] addr);
        return (addr == KBSR_ADDR) || (addr == KBDR_ADDR) ||
               (addr == DSR_ADDR)  || (addr == DDR_ADDR);
    endfunction

endpackage

// File: rtl/lc3_io_regs.sv
// rtl/lc3_io_regs.sv - keyboard/display device registers with decode hit and device strobes
module lc3_io_regs
    import lc3_mem_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_addr,
    input  logic        i_rd_en,
    input  logic        i_wr_en,
    input  logic [15:0] i_wdata,
    input  logic        i_kbd_valid,
    input  logic [7:0]  i_kbd_data,
    input  logic        i_dsp_ack,
    output logic        o_hit,
    output logic [15:0] o_rdata,
    output logic        o_dsp_valid,
    output logic [7:0]  o_dsp_data
);

    logic        r_kb_ready;
    logic        r_kb_ie;
    logic [15:0] r_kbdr;
    logic        r_dsp_ready;
    logic        r_dsp_valid;
    logic [7:0]  r_dsp_data;

    logic w_kbdr_rd;
    logic w_kbsr_wr;
    logic w_ddr_wr;

    assign o_hit     = is_io_addr(i_addr);
    assign w_kbdr_rd = i_rd_en && (i_addr == KBDR_ADDR);
    assign w_kbsr_wr = i_wr_en && (i_addr == KBSR_ADDR);
    assign w_ddr_wr  = i_wr_en && (i_addr == DDR_ADDR);

    always_comb begin
        o_rdata = 16'h0000;
        case (i_addr)
            KBSR_ADDR: o_rdata = {r_kb_ready, r_kb_ie, 14'h0000};
            KBDR_ADDR: o_rdata = r_kbdr;
            DSR_ADDR:  o_rdata = {r_dsp_ready, 15'h0000};
            default:   o_rdata = 16'h0000;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_kb_ready  <= 1'b0;
            r_kb_ie     <= 1'b0;
            r_kbdr      <= 16'h0000;
            r_dsp_ready <= 1'b1;
            r_dsp_valid <= 1'b0;
            r_dsp_data  <= 8'h00;
        end else begin
            // A new key beats a simultaneous KBDR read; the reader still sees the old key.
            if (i_kbd_valid) begin
                r_kbdr     <= {8'h00, i_kbd_data};
                r_kb_ready <= 1'b1;
            end else if (w_kbdr_rd) begin
                r_kb_ready <= 1'b0;
            end
            if (w_kbsr_wr) begin
                r_kb_ie <= i_wdata[14];
            end
            if (w_ddr_wr) begin
                r_dsp_ready <= 1'b0;
                r_dsp_data  <= i_wdata[7:0];
            end else if (i_dsp_ack) begin
                r_dsp_ready <= 1'b1;
            end
            r_dsp_valid <= w_ddr_wr;
        end
    end

    assign o_dsp_valid = r_dsp_valid;
    assign o_dsp_data  = r_dsp_data;

endmodule

// File: rtl/lc3_mem_ctrl.sv
// rtl/lc3_mem_ctrl.sv - LC-3 MAR/MDR and memory/I-O access FSM with wait-state timeout
module lc3_mem_ctrl
    import lc3_mem_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_bus_in,
    input  logic        i_ld_mar,
    input  logic        i_ld_mdr,
    input  logic        i_mio_en,
    input  logic        i_r_w,
    output logic [15:0] o_mar_out,
    output logic [15:0] o_mdr_out,
    output logic        o_ready,
    output logic        o_bus_err,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_ready,
    input  logic        i_kbd_valid,
    input  logic [7:0]  i_kbd_data,
    output logic        o_dsp_valid,
    output logic [7:0]  o_dsp_data,
    input  logic        i_dsp_ack
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t      r_state;
    logic [15:0] r_mar;
    logic [15:0] r_mdr;
    logic        r_ready;
    logic        r_bus_err;
    logic        r_mem_en;
    logic        r_mem_we;
    logic [7:0]  r_wait_cnt;

    logic        w_io_hit;
    logic        w_io_req;
    logic [15:0] w_io_rdata;

    assign w_io_req = (r_state == ST_IDLE) && i_mio_en && w_io_hit;

    lc3_io_regs u_io_regs (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_addr      (r_mar),
        .i_rd_en     (w_io_req && !i_r_w),
        .i_wr_en     (w_io_req && i_r_w),
        .i_wdata     (r_mdr),
        .i_kbd_valid (i_kbd_valid),
        .i_kbd_data  (i_kbd_data),
        .i_dsp_ack   (i_dsp_ack),
        .o_hit       (w_io_hit),
        .o_rdata     (w_io_rdata),
        .o_dsp_valid (o_dsp_valid),
        .o_dsp_data  (o_dsp_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_mar      <= 16'h0000;
            r_mdr      <= 16'h0000;
            r_ready    <= 1'b0;
            r_bus_err  <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_wait_cnt <= 8'h00;
        end else begin
            r_ready <= 1'b0;
            if (i_ld_mar) begin
                r_mar <= i_bus_in;
            end
            if (i_ld_mdr && !i_mio_en) begin
                r_mdr <= i_bus_in;
            end
            case (r_state)
                ST_IDLE: begin
                    if (i_mio_en && w_io_hit) begin
                        if (!i_r_w) begin
                            r_mdr <= w_io_rdata;
                        end
                        r_ready <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (i_mio_en) begin
                        r_mem_en   <= 1'b1;
                        r_mem_we   <= i_r_w;
                        r_wait_cnt <= 8'h00;
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (i_mem_ready) begin
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        if (!r_mem_we) begin
                            r_mdr <= i_mem_rdata;
                        end
                        r_ready <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        // Timeout: finish the access anyway so the control FSM never stalls.
                        r_mem_en  <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_bus_err <= 1'b1;
                        if (!r_mem_we) begin
                            r_mdr <= 16'h0000;
                        end
                        r_ready <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'h01;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mar_out   = r_mar;
    assign o_mdr_out   = r_mdr;
    assign o_ready     = r_ready;
    assign o_bus_err   = r_bus_err;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mar;
    assign o_mem_wdata = r_mdr;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb/tb_lc3_mem_ctrl.sv - directed self-checking bench for lc3_mem_ctrl
module tb_lc3_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] bus_in = 16'h0000;
    logic        ld_mar = 1'b0;
    logic        ld_mdr = 1'b0;
    logic        mio_en = 1'b0;
    logic        r_w = 1'b0;
    logic [15:0] mar_out, mdr_out, mem_addr, mem_wdata;
    logic        ready, bus_err, mem_en, mem_we;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ready = 1'b0;
    logic        kbd_valid = 1'b0;
    logic [7:0]  kbd_data = 8'h00;
    logic        dsp_valid;
    logic [7:0]  dsp_data;
    logic        dsp_ack = 1'b0;

    int checks = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    lc3_mem_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_bus_in    (bus_in),
        .i_ld_mar    (ld_mar),
        .i_ld_mdr    (ld_mdr),
        .i_mio_en    (mio_en),
        .i_r_w       (r_w),
        .o_mar_out   (mar_out),
        .o_mdr_out   (mdr_out),
        .o_ready     (ready),
        .o_bus_err   (bus_err),
        .o_mem_en    (mem_en),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata),
        .i_mem_ready (mem_ready),
        .i_kbd_valid (kbd_valid),
        .i_kbd_data  (kbd_data),
        .o_dsp_valid (dsp_valid),
        .o_dsp_data  (dsp_data),
        .i_dsp_ack   (dsp_ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Load MDR (writes only) and MAR, then run one single-cycle I/O access.
    task automatic io_access(input string tag, input logic [15:0] addr, input logic rw,
                             input logic [15:0] wdata, input logic kv, input logic [7:0] kd,
                             input logic ack);
        if (rw) begin
            bus_in = wdata; ld_mdr = 1'b1;
            tick();
            ld_mdr = 1'b0;
        end
        bus_in = addr; ld_mar = 1'b1;
        tick();
        ld_mar = 1'b0;
        mio_en = 1'b1; r_w = rw; kbd_valid = kv; kbd_data = kd; dsp_ack = ack;
        tick();
        check_eq({tag, "_ready"}, {15'h0, ready}, 16'h0001);
        mio_en = 1'b0; r_w = 1'b0; kbd_valid = 1'b0; dsp_ack = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check_eq("rst_mar", mar_out, 16'h0000);
        check_eq("rst_mdr", mdr_out, 16'h0000);
        check_eq("rst_ctl", {11'h0, ready, bus_err, mem_en, mem_we, dsp_valid}, 16'h0000);

        // 1: memory read, mem_ready three cycles after mem_en
        bus_in = 16'h3000; ld_mar = 1'b1;
        tick();
        ld_mar = 1'b0;
        check_eq("t1_mar", mar_out, 16'h3000);
        mio_en = 1'b1; r_w = 1'b0;
        tick();
        check_eq("t1_mem_en", {15'h0, mem_en}, 16'h0001);
        check_eq("t1_mem_we", {15'h0, mem_we}, 16'h0000);
        check_eq("t1_addr", mem_addr, 16'h3000);
        tick();
        tick();
        check_eq("t1_wait", {14'h0, ready, mem_en}, 16'h0001);
        mem_ready = 1'b1; mem_rdata = 16'h1234;
        tick();
        check_eq("t1_ready", {15'h0, ready}, 16'h0001);
        check_eq("t1_mdr", mdr_out, 16'h1234);
        check_eq("t1_mem_en_off", {15'h0, mem_en}, 16'h0000);
        mio_en = 1'b0; mem_ready = 1'b0;
        tick();
        check_eq("t1_ready_pulse", {15'h0, ready}, 16'h0000);

        // 2: zero-wait memory write
        bus_in = 16'hBEEF; ld_mdr = 1'b1;
        tick();
        ld_mdr = 1'b0; bus_in = 16'h4000; ld_mar = 1'b1;
        tick();
        ld_mar = 1'b0;
        mio_en = 1'b1; r_w = 1'b1; mem_ready = 1'b1;
        tick();
        check_eq("t2_en_we", {14'h0, mem_en, mem_we}, 16'h0003);
        check_eq("t2_wdata", mem_wdata, 16'hBEEF);
        check_eq("t2_addr", mem_addr, 16'h4000);
        check_eq("t2_not_ready", {15'h0, ready}, 16'h0000);
        tick();
        check_eq("t2_ready", {15'h0, ready}, 16'h0001);
        check_eq("t2_mdr_kept", mdr_out, 16'hBEEF);
        mio_en = 1'b0; r_w = 1'b0; mem_ready = 1'b0;
        tick();
        check_eq("t2_after", {14'h0, ready, mem_en}, 16'h0000);

        // 3: keyboard registers
        kbd_valid = 1'b1; kbd_data = 8'h41;
        tick();
        kbd_valid = 1'b0;
        io_access("t3_kbsr", 16'hFE00, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
        check_eq("t3_kbsr", mdr_out, 16'h8000);
        io_access("t3_kbdr", 16'hFE02, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
        check_eq("t3_kbdr", mdr_out, 16'h0041);
        io_access("t3_kbsr2", 16'hFE00, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
        check_eq("t3_kbsr2", mdr_out, 16'h0000);
        io_access("t3_ie_wr", 16'hFE00, 1'b1, 16'hFFFF, 1'b0, 8'h0, 1'b0);
        io_access("t3_ie_rd", 16'hFE00, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
        check_eq("t3_ie", mdr_out, 16'h4000);
        kbd_valid = 1'b1; kbd_data = 8'h42;
        tick();
        kbd_valid = 1'b0;
        io_access("t3_race", 16'hFE02, 1'b0, 16'h0, 1'b1, 8'h43, 1'b0);
        check_eq("t3_race_old", mdr_out, 16'h0042);
        io_access("t3_race_st", 16'hFE00, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
        check_eq("t3_race_st", mdr_out, 16'hC000);
        io_access("t3_race_new", 16'hFE02, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
        check_eq("t3_race_new", mdr_out, 16'h0043);

        // 4: display registers
        io_access("t4_ddr", 16'hFE06, 1'b1, 16'h0058, 1'b0, 8'h0, 1'b0);
        check_eq("t4_dsp_valid", {15'h0, dsp_valid}, 16'h0001);
        check_eq("t4_dsp_data", {8'h0, dsp_data}, 16'h0058);
        tick();
        check_eq("t4_dsp_pulse", {15'h0, dsp_valid}, 16'h0000);
        io_access("t4_dsr_busy", 16'hFE04, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
        check_eq("t4_dsr_busy", mdr_out, 16'h0000);
        dsp_ack = 1'b1;
        tick();
        dsp_ack = 1'b0;
        io_access("t4_dsr_rdy", 16'hFE04, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
        check_eq("t4_dsr_rdy", mdr_out, 16'h8000);
        io_access("t4_ddr_rd", 16'hFE06, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
        check_eq("t4_ddr_rd", mdr_out, 16'h0000);
        io_access("t4_ack_race", 16'hFE06, 1'b1, 16'h0021, 1'b0, 8'h0, 1'b1);
        check_eq("t4_ack_data", {8'h0, dsp_data}, 16'h0021);
        io_access("t4_ack_dsr", 16'hFE04, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
        check_eq("t4_ack_dsr", mdr_out, 16'h0000);

        // 5: timeout on a read that never completes
        check_eq("t5_err_before", {15'h0, bus_err}, 16'h0000);
        bus_in = 16'h1111; ld_mdr = 1'b1;
        tick();
        ld_mdr = 1'b0; bus_in = 16'h5000; ld_mar = 1'b1;
        tick();
        ld_mar = 1'b0;
        mio_en = 1'b1; r_w = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ready && n < 400);
        check_eq("t5_latency", 16'(n), 16'd256);
        check_eq("t5_bus_err", {15'h0, bus_err}, 16'h0001);
        check_eq("t5_mdr", mdr_out, 16'h0000);
        check_eq("t5_mem_en", {15'h0, mem_en}, 16'h0000);
        mio_en = 1'b0;
        tick();
        tick();
        check_eq("t5_sticky", {15'h0, bus_err}, 16'h0001);

        // 6: reset in the middle of a memory wait
        bus_in = 16'h6000; ld_mar = 1'b1;
        tick();
        ld_mar = 1'b0;
        mio_en = 1'b1; r_w = 1'b0;
        tick();
        tick();
        tick();
        check_eq("t6_pending", {15'h0, mem_en}, 16'h0001);
        rst = 1'b1; mio_en = 1'b0;
        tick();
        check_eq("t6_ctl", {11'h0, ready, bus_err, mem_en, mem_we, dsp_valid}, 16'h0000);
        check_eq("t6_mar", mar_out, 16'h0000);
        check_eq("t6_mdr", mdr_out, 16'h0000);
        check_eq("t6_dsp_data", {8'h0, dsp_data}, 16'h0000);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ready) n++;
        end
        check_eq("t6_no_ready", 16'(n), 16'd0);
        io_access("t6_dsr", 16'hFE04, 1'b0, 16'h0, 1'b0, 8'h0, 1'b0);
        check_eq("t6_dsr", mdr_out, 16'h8000);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
